// File: rtl/kb_autotype_pkg.sv
// kb_autotype_pkg
//   Constants shared by the autotype sequencer and its FIFO.
//   - Layout of an 8-bit key code: [7]=shift, [6:3]=matrix row, [2:0]=matrix column.
//   - The CPC SHIFT key position, which is pressed alongside shifted codes.
//   - The pause row value (holds a time slot without pressing anything).
//   - The sequencer state encoding.
package kb_autotype_pkg;

    localparam int SHIFT_BIT = 7;
    localparam int ROW_MSB   = 6;
    localparam int ROW_LSB   = 3;
    localparam int COL_MSB   = 2;
    localparam int COL_LSB   = 0;

    localparam logic [3:0] PAUSE_ROW     = 4'hF;
    localparam logic [3:0] LAST_KEY_ROW  = 4'd9;
    localparam logic [3:0] CPC_SHIFT_ROW = 4'd2;
    localparam logic [2:0] CPC_SHIFT_COL = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PRESS = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Rows 0..9 exist in the 10x8 matrix; everything else is pause or invalid.
    function automatic logic is_key_row(input logic [3:0] row);
        return row <= LAST_KEY_ROW;
    endfunction

endpackage

// File: rtl/kb_autotype_fifo.sv
// kb_autotype_fifo
//   Synchronous 8-bit code FIFO, depth 2**AW, with flush.
//   Ports:
//     clk, reset   clock and asynchronous active-high reset
//     flush        empties the FIFO; wins over a push or pop in the same cycle
//     push/wr_data write request and data (ignored when full)
//     pop          advance the head (ignored when empty)
//     rd_data      current head entry, visible without a read delay
//     full/empty   status derived from the (AW+1)-bit pointers
module kb_autotype_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        push_ok;
    logic        pop_ok;

    // The extra pointer MSB distinguishes full from empty when the
    // address bits coincide.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A full FIFO refuses a write even if the head is popped on the same edge.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // The sequencer latches the head in the same cycle it pops it, so the
    // head is read straight out of the array rather than through a register.
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/kb_autotype_sequencer.sv
// kb_autotype_sequencer
//   Types a queue of CPC key codes into the keyboard matrix, one key per
//   slot, with press and release times measured in video frames. The merged
//   active-low columns replace the raw matrix columns on the PPI port-A path.
//   Ports:
//     clk, reset   system clock; asynchronous active-high reset
//     frame_tick   1-clk pulse per video frame
//     wr_data/wr_valid/wr_ready  code write interface (write when valid&ready)
//     abort        flush queue and release the injected key
//     lock_user    while busy, mask out the user's keys
//     rowselect    PPI row select
//     columns_kbd  user columns from the PS/2 matrix (active low)
//     columns      merged columns (active low, combinational)
//     busy         queue not empty or sequencer not idle
//     err          sticky flag: a code with row 10..14 was fetched
module kb_autotype_sequencer
    import kb_autotype_pkg::*;
#(
    parameter int PRESS_FRAMES = 3,
    parameter int GAP_FRAMES   = 2,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       abort,
    input  logic       lock_user,
    input  logic [3:0] rowselect,
    input  logic [7:0] columns_kbd,
    output logic [7:0] columns,
    output logic       busy,
    output logic       err
);

    // Counter values at which the terminating tick arrives.
    localparam logic [7:0] PRESS_LAST = 8'(PRESS_FRAMES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);

    state_t      state_reg;
    logic [7:0]  frame_cnt_reg;
    logic [3:0]  key_row_reg;
    logic [2:0]  key_col_reg;
    logic        key_shift_reg;
    logic        key_down_reg;
    logic        err_reg;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic [3:0]  head_row;
    logic [7:0]  inj_cols;
    logic [7:0]  user_cols;

    kb_autotype_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .push    (wr_valid),
        .wr_data (wr_data),
        .pop     (state_reg == ST_FETCH),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_row = fifo_head[ROW_MSB:ROW_LSB];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= '0;
            key_row_reg   <= '0;
            key_col_reg   <= '0;
            key_shift_reg <= 1'b0;
            key_down_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else if (abort) begin
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= '0;
            key_down_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    key_row_reg   <= head_row;
                    key_col_reg   <= fifo_head[COL_MSB:COL_LSB];
                    key_shift_reg <= fifo_head[SHIFT_BIT];
                    frame_cnt_reg <= '0;
                    if (is_key_row(head_row)) begin
                        state_reg    <= ST_PRESS;
                        key_down_reg <= 1'b1;
                    end else if (head_row == PAUSE_ROW) begin
                        // Pause occupies a press slot with nothing held down.
                        state_reg    <= ST_PRESS;
                        key_down_reg <= 1'b0;
                    end else begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    if (frame_tick) begin
                        if (frame_cnt_reg == PRESS_LAST) begin
                            // Key and shift release together on this edge.
                            state_reg     <= ST_GAP;
                            frame_cnt_reg <= '0;
                            key_down_reg  <= 1'b0;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (frame_tick) begin
                        if (frame_cnt_reg == GAP_LAST) begin
                            state_reg     <= fifo_empty ? ST_IDLE : ST_FETCH;
                            frame_cnt_reg <= '0;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Injected columns: a held key only ever has row 0..9, so a rowselect of
    // 10..15 never matches and leaves every bit released.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_inj
            assign inj_cols[gi] = !(key_down_reg &&
                ((rowselect == key_row_reg && key_col_reg == 3'(gi)) ||
                 (key_shift_reg && rowselect == CPC_SHIFT_ROW &&
                  3'(gi) == CPC_SHIFT_COL)));
        end
    endgenerate

    assign busy      = !fifo_empty || (state_reg != ST_IDLE);
    assign user_cols = (busy && lock_user) ? 8'hFF : columns_kbd;
    assign columns   = user_cols & inj_cols;
    assign wr_ready  = !fifo_full;
    assign err       = err_reg;

endmodule

// File: tb/tb_kb_autotype_sequencer.sv
`timescale 1ns/1ps
module tb_kb_autotype_sequencer;

    localparam int PRESS_N = 3;
    localparam int GAP_N   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       abort = 1'b0;
    logic       lock_user = 1'b0;
    logic [3:0] rowselect = 4'd0;
    logic [7:0] columns_kbd = 8'hFF;
    logic       wr_ready;
    logic [7:0] columns;
    logic       busy;
    logic       err;

    int check_cnt = 0;
    int fail_cnt  = 0;

    always #50 clk = ~clk;

    kb_autotype_sequencer #(
        .PRESS_FRAMES(PRESS_N),
        .GAP_FRAMES  (GAP_N),
        .FIFO_AW     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .abort      (abort),
        .lock_user  (lock_user),
        .rowselect  (rowselect),
        .columns_kbd(columns_kbd),
        .columns    (columns),
        .busy       (busy),
        .err        (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Each accepted code is given a start frame; a real key is down for
    // PRESS_N frames from its start, and the next code may start PRESS_N+GAP_N
    // frames later. Invalid-row codes take no frames and raise err.
    typedef struct {
        int         start;
        logic [7:0] code;
    } sched_t;

    sched_t sched[$];
    int     frame_no;
    int     next_free;
    int     err_frame;

    function automatic bit is_bad_row(input logic [7:0] code);
        return (code[6:3] >= 4'd10) && (code[6:3] <= 4'd14);
    endfunction

    function automatic void model_reset();
        sched.delete();
        frame_no  = -1;
        next_free = 0;
        err_frame = -1;
    endfunction

    function automatic void model_push(input logic [7:0] code);
        sched_t e;
        e.start = (frame_no > next_free) ? frame_no : next_free;
        e.code  = code;
        sched.push_back(e);
        if (is_bad_row(code)) begin
            if (err_frame < 0 || e.start < err_frame) err_frame = e.start;
        end else begin
            next_free = e.start + PRESS_N + GAP_N;
        end
    endfunction

    function automatic int model_pending();
        int n = 0;
        foreach (sched[i]) if (sched[i].start > frame_no) n++;
        return n;
    endfunction

    function automatic logic model_busy();
        return frame_no < next_free;
    endfunction

    function automatic logic model_err();
        return (err_frame >= 0) && (err_frame <= frame_no);
    endfunction

    function automatic logic [7:0] model_cols(input int rs, input logic lock, input logic [7:0] kbd);
        logic [7:0] inj;
        logic [7:0] user;
        inj = 8'hFF;
        foreach (sched[i]) begin
            if (sched[i].start <= frame_no && frame_no < sched[i].start + PRESS_N &&
                sched[i].code[6:3] <= 4'd9) begin
                if (rs == int'(sched[i].code[6:3])) inj[sched[i].code[2:0]] = 1'b0;
                if (sched[i].code[7] && rs == 2) inj[5] = 1'b0;
            end
        end
        user = (model_busy() && lock) ? 8'hFF : kbd;
        return user & inj;
    endfunction

    function automatic logic [7:0] rand_code();
        logic [3:0] row;
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 12)                         row = 4'($urandom_range(0, 9));
        else if (r < 14)                    row = 4'hF;
        else if (model_pending() == 0)      row = 4'($urandom_range(10, 14));
        else                                row = 4'($urandom_range(0, 9));
        return {1'($urandom_range(0, 1)), row, 3'($urandom_range(0, 7))};
    endfunction

    // One video frame of 12 clocks: tick, optional write, then a full
    // rowselect sweep compared against the model.
    task automatic run_frame(input bit do_push, input logic [7:0] code);
        logic [7:0] exp_cols;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        frame_no++;
        while (sched.size() > 0 && sched[0].start + PRESS_N + GAP_N < frame_no)
            void'(sched.pop_front());
        step();
        if (do_push) begin
            wr_valid = 1'b1;
            wr_data  = code;
            model_push(code);
        end
        lock_user   = 1'($urandom_range(0, 1));
        columns_kbd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        step();
        wr_valid = 1'b0;
        repeat (7) step();
        check_val($sformatf("busy f%0d", frame_no), 32'(busy), 32'(model_busy()));
        check_val($sformatf("err f%0d", frame_no), 32'(err), 32'(model_err()));
        check_val($sformatf("wr_ready f%0d", frame_no), 32'(wr_ready), 32'(model_pending() < 16));
        for (int rs = 0; rs < 16; rs++) begin
            rowselect = 4'(rs);
            #1;
            exp_cols = model_cols(rs, lock_user, columns_kbd);
            check_val($sformatf("cols f%0d rs%0d", frame_no, rs), 32'(columns), 32'(exp_cols));
        end
        $display("frame %0d push=%0b code=%02h busy=%0b err=%0b", frame_no, do_push, code, busy, err);
        repeat (2) step();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        wr_valid   = 1'b0;
        abort      = 1'b0;
        frame_tick = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        model_reset();
    endtask

    initial begin
        int accepted;
        bit seen;

        model_reset();

        // ---- reset values ----
        do_reset();
        check_val("rst wr_ready", 32'(wr_ready), 32'd1);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst err", 32'(err), 32'd0);
        lock_user   = 1'b1;
        columns_kbd = 8'h5A;
        rowselect   = 4'd4;
        #1;
        check_val("rst cols passthru", 32'(columns), 32'h5A);
        $display("reset checks done");

        // ---- directed sequences through the frame model ----
        run_frame(1'b1, 8'h25);                       // K
        repeat (6) run_frame(1'b0, 8'h00);
        run_frame(1'b1, 8'hC5);                       // shift + A
        repeat (6) run_frame(1'b0, 8'h00);
        run_frame(1'b1, 8'h25);                       // K twice
        run_frame(1'b1, 8'h25);
        repeat (11) run_frame(1'b0, 8'h00);
        run_frame(1'b1, 8'h58);                       // invalid row 11
        run_frame(1'b1, 8'h78);                       // pause
        repeat (7) run_frame(1'b0, 8'h00);

        // ---- randomized traffic ----
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 2) == 0 && model_pending() < 12)
                run_frame(1'b1, rand_code());
            else
                run_frame(1'b0, 8'h00);
        end

        // ---- FIFO full behaviour (no ticks: first code stays pressed) ----
        do_reset();
        lock_user   = 1'b0;
        columns_kbd = 8'hFF;
        wr_data     = 8'h25;
        wr_valid    = 1'b1;
        accepted    = 0;
        for (int i = 0; i < 40 && wr_ready; i++) begin
            step();
            accepted++;
        end
        check_val("fill accepted", 32'(accepted), 32'd17);
        repeat (3) step();
        check_val("full refuses", 32'(wr_ready), 32'd0);
        rowselect = 4'd4;
        #1;
        check_val("full key held", 32'(columns), 32'hDF);
        $display("fifo filled accepted=%0d", accepted);

        // Hold the write while the sequencer works toward its next pop.
        wr_data = 8'h31;
        seen    = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            frame_tick = (c % 4 == 0);
            step();
            frame_tick = 1'b0;
            if (wr_ready) seen = 1'b1;
        end
        check_val("pop frees slot", 32'(seen), 32'd1);
        step();
        check_val("held write taken", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
        rowselect = 4'd4;
        #1;
        check_val("second K held", 32'(columns), 32'hDF);
        $display("pop with held write done");

        // ---- abort mid-press, with a competing write ----
        abort    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h25;
        step();
        abort    = 1'b0;
        wr_valid = 1'b0;
        check_val("abort cols", 32'(columns), 32'hFF);
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort wr_ready", 32'(wr_ready), 32'd1);
        repeat (3) step();
        check_val("abort stays idle", 32'(busy), 32'd0);
        columns_kbd = 8'hA5;
        #1;
        check_val("abort passthru", 32'(columns), 32'hA5);
        $display("abort done");

        // ---- invalid code, then async reset mid-press ----
        columns_kbd = 8'hFF;
        wr_valid = 1'b1;
        wr_data  = 8'h58;
        step();
        wr_data  = 8'h31;                             // row 6 col 1
        step();
        wr_valid = 1'b0;
        repeat (5) step();
        check_val("err set", 32'(err), 32'd1);
        rowselect = 4'd6;
        #1;
        check_val("row6 col1 held", 32'(columns), 32'hFD);
        lock_user   = 1'b1;
        columns_kbd = 8'h00;
        #1;
        check_val("locked inj only", 32'(columns), 32'hFD);
        lock_user   = 1'b0;
        columns_kbd = 8'hFF;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("async rst cols", 32'(columns), 32'hFF);
        check_val("async rst busy", 32'(busy), 32'd0);
        check_val("async rst err", 32'(err), 32'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        check_val("post rst empty", 32'(busy), 32'd0);
        $display("async reset done");

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
